spi_master: RTL and testbench

SPI master controller that issues single-register read transactions to the `slave` register-file block. It drives `ss`, `sck` and `MOSI` from the system clock, sends an 8-bit register address, then clocks 8 bits of register data back over `MISO` and presents them on `rdata` with a one-cycle `done` strobe. All four cpol/cpoh modes are supported, and the mode pins are shared with the slave.

---
 rtl/spi_master.sv | 165 ++++++++++++++++
 tb/tb_spi_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master that performs one register read per transaction: 8 address bits out on MOSI,
// then 8 data bits in on MISO, LSB first, in any of the four cpol/cpoh modes.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic       cpol,
  input  logic       cpoh,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ss,
  output logic       sck,
  output logic       MOSI,
  input  logic       MISO
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_div, w_div_next;
  logic [4:0] r_edge, w_edge_next;
  logic [7:0] r_addr, w_addr_next;
  logic [7:0] r_shift, w_shift_next;
  logic [7:0] r_rdata, w_rdata_next;
  logic       r_cpol, w_cpol_next;
  logic       r_cpoh, w_cpoh_next;
  logic       r_ss, w_ss_next;
  logic       r_sck, w_sck_next;
  logic       r_mosi, w_mosi_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;

  logic       w_tick;
  logic       w_lead;
  logic       w_sample_lead;
  logic       w_data_phase;
  logic [4:0] w_next_period;

  // r_edge is the index of the next sck edge; bit 0 clear means a leading edge
  assign w_tick        = (r_div == DIV_LAST);
  assign w_lead        = ~r_edge[0];
  assign w_sample_lead = ~(r_cpol ^ r_cpoh);
  assign w_data_phase  = r_edge[4];
  assign w_next_period = {1'b0, r_edge[4:1]} + 5'd1;

  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_edge_next  = r_edge;
    w_addr_next  = r_addr;
    w_shift_next = r_shift;
    w_rdata_next = r_rdata;
    w_cpol_next  = r_cpol;
    w_cpoh_next  = r_cpoh;
    w_ss_next    = r_ss;
    w_sck_next   = r_sck;
    w_mosi_next  = r_mosi;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    case (r_state)
      IDLE: begin
        w_ss_next   = 1'b0;
        w_mosi_next = 1'b0;
        w_busy_next = 1'b0;
        w_sck_next  = cpol;
        w_div_next  = 8'd0;
        w_edge_next = 5'd0;
        if (start) begin
          w_state_next = LEAD;
          w_addr_next  = addr;
          w_cpol_next  = cpol;
          w_cpoh_next  = cpoh;
          w_ss_next    = 1'b1;
          w_busy_next  = 1'b1;
          w_mosi_next  = (cpol ^ cpoh) ? 1'b0 : addr[0];
        end
      end

      LEAD, SHIFT: begin
        w_div_next = r_div + 8'd1;
        if (w_tick) begin
          w_div_next  = 8'd0;
          w_sck_next  = ~r_sck;
          w_edge_next = r_edge + 5'd1;
          if (w_lead == w_sample_lead) begin
            if (w_data_phase) w_shift_next = {MISO, r_shift[7:1]};
          end else if (w_lead) begin
            w_mosi_next = w_data_phase ? 1'b0 : r_addr[r_edge[3:1]];
          end else begin
            // trailing-edge change presents the bit for the following period
            w_mosi_next = (w_next_period >= 5'd8) ? 1'b0 : r_addr[w_next_period[2:0]];
          end
          if (r_state == LEAD)          w_state_next = SHIFT;
          else if (r_edge == 5'd31)     w_state_next = TRAIL;
        end
      end

      TRAIL: begin
        w_div_next = r_div + 8'd1;
        if (w_tick) begin
          w_div_next   = 8'd0;
          w_state_next = DONE;
          w_ss_next    = 1'b0;
          w_done_next  = 1'b1;
          w_rdata_next = r_shift;
        end
      end

      DONE: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
        w_mosi_next  = 1'b0;
        w_sck_next   = cpol;
      end

      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_div   <= 8'd0;
      r_edge  <= 5'd0;
      r_addr  <= 8'd0;
      r_shift <= 8'd0;
      r_rdata <= 8'h00;
      r_cpol  <= 1'b0;
      r_cpoh  <= 1'b0;
      r_ss    <= 1'b0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_edge  <= w_edge_next;
      r_addr  <= w_addr_next;
      r_shift <= w_shift_next;
      r_rdata <= w_rdata_next;
      r_cpol  <= w_cpol_next;
      r_cpoh  <= w_cpoh_next;
      r_ss    <= w_ss_next;
      r_sck   <= w_sck_next;
      r_mosi  <= w_mosi_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign ss    = r_ss;
  assign sck   = r_sck;
  assign MOSI  = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV 4 and 2), each with a behavioural SPI slave
// register file that decodes the address from MOSI and answers on MISO.
module tb_spi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, start, cpol, cpoh, busy, done, ss, sck, mosi;
  logic [1:0][7:0] addr, rdata;

  logic [7:0] regs [1:8];
  logic [7:0] exp_addr [2];
  logic       exp_cpol [2];
  logic       exp_cpoh [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cd_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic logic [7:0] reg_read(input logic [7:0] a);
    return (a >= 8'd1 && a <= 8'd8) ? regs[a] : 8'h00;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int CD = (gi == 0) ? 4 : 2;
    logic       miso_drv = 1'b0;
    int         edge_cnt = 0;
    int         mosi_age = 0;
    int         since_sample = 1000;
    logic       in_frame = 1'b0;
    logic       ss_prev = 1'b0;
    logic       sck_prev = 1'b0;
    logic       mosi_prev = 1'b0;
    logic [7:0] got_addr = 8'h00;
    logic [7:0] slave_data = 8'h00;

    spi_master #(.CLK_DIV(CD)) u_dut (
      .clk(clk), .reset(rst_n[gi]), .start(start[gi]), .addr(addr[gi]),
      .cpol(cpol[gi]), .cpoh(cpoh[gi]), .busy(busy[gi]), .done(done[gi]),
      .rdata(rdata[gi]), .ss(ss[gi]), .sck(sck[gi]), .MOSI(mosi[gi]), .MISO(miso_drv)
    );

    // Slave + protocol monitor, evaluated on the falling clock edge
    always @(negedge clk) begin
      int period;
      int q;
      bit sample;
      if (!rst_n[gi]) begin
        in_frame = 1'b0;
      end else if (ss[gi] && !ss_prev) begin
        in_frame     = 1'b1;
        edge_cnt     = 0;
        got_addr     = 8'h00;
        since_sample = 1000;
        miso_drv     = 1'($urandom);
        check("sck_idle_before_ss", sck[gi], exp_cpol[gi]);
      end else if (in_frame && ss[gi] && (sck[gi] != sck_prev)) begin
        period = edge_cnt / 2;
        sample = ((edge_cnt % 2) == 0) == ((exp_cpol[gi] ^ exp_cpoh[gi]) == 1'b0);
        if (sample) begin
          check("mosi_setup", 32'(mosi_age >= CD), 1);
          if (period < 8) got_addr[period] = mosi_prev;
          else check("mosi_zero_data_phase", mosi_prev, 0);
          since_sample = 0;
        end else begin
          q = (exp_cpol[gi] ^ exp_cpoh[gi]) ? period : period + 1;
          if (q == 8) slave_data = reg_read(got_addr);
          miso_drv = (q >= 8 && q <= 15) ? slave_data[q-8] : 1'($urandom);
        end
        edge_cnt++;
      end else if (in_frame && !ss[gi] && ss_prev) begin
        check("sck_edge_count", edge_cnt, 32);
        check("sck_idle_after_ss", sck[gi], exp_cpol[gi]);
        check("mosi_address", got_addr, exp_addr[gi]);
        in_frame = 1'b0;
      end
      if (in_frame && (mosi[gi] != mosi_prev)) check("mosi_hold", 32'(since_sample >= CD), 1);
      mosi_age     = (mosi[gi] == mosi_prev) ? mosi_age + 1 : 1;
      since_sample = since_sample + 1;
      ss_prev      = ss[gi];
      sck_prev     = sck[gi];
      mosi_prev    = mosi[gi];
    end
  end

  // One read; the reference is 33*CLK_DIV+1 cycles to done and rdata = regs[addr].
  task automatic run_txn(input int d, input logic [7:0] a, input logic pol, input logic pha,
                         input bit jitter, input bit ign);
    int cd;
    int lat;
    cd = cd_of(d);
    addr[d] = a; cpol[d] = pol; cpoh[d] = pha;
    exp_addr[d] = a; exp_cpol[d] = pol; exp_cpoh[d] = pha;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    lat = 1;
    check("ss_rise", ss[d], 1);
    check("busy_rise", busy[d], 1);
    while (!done[d] && lat < 40 * cd) begin
      if (jitter) begin
        addr[d] = 8'($urandom); cpol[d] = 1'($urandom); cpoh[d] = 1'($urandom);
      end
      start[d] = ign && (lat == 10 || lat == 70);
      @(negedge clk);
      lat++;
    end
    start[d] = ign;
    check("latency", lat, 33 * cd + 1);
    check("rdata", rdata[d], regs[a]);
    check("busy_in_done", busy[d], 1);
    check("ss_in_done", ss[d], 0);
    @(negedge clk);
    start[d] = 1'b0;
    check("busy_fall", busy[d], 0);
    check("done_one_cycle", done[d], 0);
    check("idle_sck", sck[d], cpol[d]);
    if (ign) begin
      repeat (3 * cd) begin
        @(negedge clk);
        check("ignored_start", {ss[d], busy[d], done[d]}, 0);
      end
    end
    $display("txn dut%0d addr=%02h cpol=%0d cpoh=%0d rdata=%02h latency=%0d", d, a, pol, pha,
             rdata[d], lat);
  endtask

  initial begin
    int lat;
    int n;
    int ss_low;
    bit saw_done;
    rst_n = 2'b00; start = 2'b00; addr = '0; cpol = 2'b11; cpoh = 2'b00;
    for (int i = 1; i <= 8; i++) regs[i] = 8'($urandom);
    for (int d = 0; d < 2; d++) begin
      exp_addr[d] = 8'h00; exp_cpol[d] = 1'b0; exp_cpoh[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ss", ss[d], 0);
      check("reset_sck", sck[d], 0);
      check("reset_mosi", mosi[d], 0);
      check("reset_busy", busy[d], 0);
      check("reset_done", done[d], 0);
      check("reset_rdata", rdata[d], 8'h00);
    end
    rst_n = 2'b11;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("sck_tracks_cpol", sck[d], 1);

    regs[3] = 8'hA5;
    run_txn(0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    regs[8] = 8'h3C;
    for (int m = 1; m < 4; m++) run_txn(0, 8'h08, 1'(m >> 1), 1'(m), 1'b0, 1'b0);

    run_txn(0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    run_txn(0, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0);

    // Abandon a transfer at sck edge 12 with the asynchronous reset
    addr[0] = 8'h05; cpol[0] = 1'b0; cpoh[0] = 1'b1;
    exp_addr[0] = 8'h05; exp_cpol[0] = 1'b0; exp_cpoh[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    lat = 1;
    while (lat < 1 + 13 * 4) begin
      @(negedge clk);
      lat++;
    end
    check("pre_reset_ss", ss[0], 1);
    #2 rst_n[0] = 1'b0;
    #1;
    check("reset_async_ss", ss[0], 0);
    check("reset_async_sck", sck[0], 0);
    check("reset_async_mosi", mosi[0], 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done[0]) saw_done = 1'b1;
    end
    check("reset_no_done", saw_done, 0);
    check("reset_busy_low", busy[0], 0);
    #2 rst_n[0] = 1'b1;
    @(negedge clk);
    run_txn(0, 8'($urandom_range(1, 8)), 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back reads on the CLK_DIV=2 instance with start held high
    regs[1] = 8'h11; regs[2] = 8'h22;
    addr[1] = 8'h01; cpol[1] = 1'b0; cpoh[1] = 1'b0;
    exp_addr[1] = 8'h01; exp_cpol[1] = 1'b0; exp_cpoh[1] = 1'b0;
    start[1] = 1'b1;
    @(negedge clk);
    n = 1;
    while (!done[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done1_cycle", n, 67);
    check("b2b_rdata1", rdata[1], 8'h11);
    ss_low = 0;
    #1 addr[1] = 8'h02;
    exp_addr[1] = 8'h02;
    while (!ss[1] && n < 200) begin
      ss_low++;
      @(negedge clk);
      n++;
    end
    check("b2b_ss_gap", 32'(ss_low >= 1), 1);
    while (!done[1] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done2_cycle", n, 135);
    check("b2b_rdata2", rdata[1], 8'h22);
    start[1] = 1'b0;
    $display("txn dut1 back-to-back rdata=%02h done_cycles=67/%0d", rdata[1], n);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      for (int r = 1; r <= 8; r++) regs[r] = 8'($urandom);
      run_txn(d, 8'($urandom_range(1, 8)), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
